hazard_fwd_unit: RTL

//  Hazard/forwarding control for the ID stage of the 3-stage (ID->EX->WB) pipeline.

---
 rtl/hazard_fwd_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the ID stage of the ID->EX->WB pipeline.
// Optional performance counters are enabled with the HAZ_PERF_EN macro.
module hazard_fwd_unit #(
    parameter int RW_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RW_W-1:0] id_aa,
    input  logic [RW_W-1:0] id_ba,
    input  logic            id_ma,
    input  logic            id_mb,
    input  logic [RW_W-1:0] id_da,
    input  logic            id_rw,
    input  logic            id_load,
    input  logic            flush,
    output logic            ha,
    output logic            hb,
    output logic            stall,
`ifdef HAZ_PERF_EN
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_fwd,
`endif
    output logic            bubble
);

    logic [RW_W-1:0] r_ex_da;
    logic            r_ex_rw;
    logic            r_ex_load;
    logic [RW_W-1:0] r_wb_da;
    logic            r_wb_rw;

    logic w_ma_ex;
    logic w_mb_ex;
    logic w_ma_wb;
    logic w_mb_wb;
    logic w_hazard;

    // R0 is hardwired zero, so a write to it can never create a dependency.
    function automatic logic src_match(
        input logic            valid,
        input logic            mux_sel,
        input logic            dst_rw,
        input logic [RW_W-1:0] dst_da,
        input logic [RW_W-1:0] src
    );
        return valid & ~mux_sel & dst_rw & (dst_da != {RW_W{1'b0}}) & (dst_da == src);
    endfunction

    assign w_ma_ex = src_match(id_valid, id_ma, r_ex_rw, r_ex_da, id_aa);
    assign w_mb_ex = src_match(id_valid, id_mb, r_ex_rw, r_ex_da, id_ba);
    assign w_ma_wb = src_match(id_valid, id_ma, r_wb_rw, r_wb_da, id_aa);
    assign w_mb_wb = src_match(id_valid, id_mb, r_wb_rw, r_wb_da, id_ba);

    // A load result only exists in WB, and a WB value is written this cycle, so neither forwards.
    assign w_hazard = ((w_ma_ex | w_mb_ex) & r_ex_load)
                    | (w_ma_wb & ~w_ma_ex)
                    | (w_mb_wb & ~w_mb_ex);

    // Operand-mux selects and pipeline controls; flush wins over a stall.
    always_comb begin
        ha     = 1'b0;
        hb     = 1'b0;
        stall  = 1'b0;
        bubble = 1'b0;
        if (!rst_n) begin
            bubble = 1'b0;
        end else if (flush) begin
            bubble = 1'b1;
        end else if (w_hazard) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end else begin
            ha = w_ma_ex & ~r_ex_load;
            hb = w_mb_ex & ~r_ex_load;
        end
    end

    // Shadow destination fields of the EX and WB instructions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_da   <= {RW_W{1'b0}};
            r_ex_rw   <= 1'b0;
            r_ex_load <= 1'b0;
            r_wb_da   <= {RW_W{1'b0}};
            r_wb_rw   <= 1'b0;
        end else begin
            r_wb_da <= r_ex_da;
            r_wb_rw <= r_ex_rw;
            if (bubble) begin
                r_ex_da   <= {RW_W{1'b0}};
                r_ex_rw   <= 1'b0;
                r_ex_load <= 1'b0;
            end else begin
                r_ex_da   <= id_da;
                r_ex_rw   <= id_rw & id_valid;
                r_ex_load <= id_load;
            end
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_fwd;

    // Free-running event counters that wrap at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_stall <= 32'd0;
            r_perf_fwd   <= 32'd0;
        end else begin
            if (stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (ha | hb) begin
                r_perf_fwd <= r_perf_fwd + 32'd1;
            end
        end
    end

    assign perf_stall = rst_n ? r_perf_stall : 32'd0;
    assign perf_fwd   = rst_n ? r_perf_fwd   : 32'd0;
`endif

endmodule
